// File: rtl/uart_cmd_parser.sv
// Monitor command-line parser: pops RX bytes, tokenises "<cmd> [hex] [hex] CR" and
// presents one held command record. Define UART_CMD_ECHO_EN to echo bytes and CR->LF.
module uart_cmd_parser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_fifo_dvalid,
  input  logic [7:0]  rx_rdata,
  output logic        rx_rden,
  input  logic        tx_fifo_full,
  output logic [7:0]  tx_wdata,
  output logic        tx_wten,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [31:0] cmd_arg0,
  output logic [31:0] cmd_arg1,
  output logic [1:0]  cmd_nargs,
  output logic        cmd_err,
  input  logic        cmd_ack
);

`ifdef UART_CMD_ECHO_EN
  typedef enum logic [1:0] {S_CMD = 2'd0, S_ARG = 2'd1, S_LF = 2'd2, S_WAIT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_CMD = 2'd0, S_ARG = 2'd1, S_WAIT = 2'd3} state_t;
`endif

  state_t      state_q, state_d;
  logic [7:0]  code_q, code_d;
  logic [31:0] arg0_q, arg0_d;
  logic [31:0] arg1_q, arg1_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  nargs_q, nargs_d;
  logic        err_q, err_d;
  logic        digit_seen_q, digit_seen_d;
  logic        consume;
  logic [4:0]  hex;
`ifdef UART_CMD_ECHO_EN
  logic        blank_q, blank_d;
  logic        lf_wr;
`else
  logic        unused_tx_full;
  assign unused_tx_full = tx_fifo_full;
`endif

  // Returns {is_hex, nibble} for an ASCII hex digit.
  function automatic logic [4:0] hex_decode(input logic [7:0] b);
    logic [4:0] r;
    r = 5'd0;
    if (b >= 8'h30 && b <= 8'h39)
      r = {1'b1, b[3:0]};
    else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
      r = {1'b1, b[3:0] + 4'd9};
    return r;
  endfunction

  assign hex = hex_decode(rx_rdata);

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    arg0_d       = arg0_q;
    arg1_d       = arg1_q;
    acc_d        = acc_q;
    nargs_d      = nargs_q;
    err_d        = err_q;
    digit_seen_d = digit_seen_q;
    consume      = 1'b0;
`ifdef UART_CMD_ECHO_EN
    blank_d      = blank_q;
    lf_wr        = 1'b0;
    consume      = rst_n && rx_fifo_dvalid && !tx_fifo_full &&
                   (state_q == S_CMD || state_q == S_ARG);
`else
    consume      = rst_n && rx_fifo_dvalid && (state_q == S_CMD || state_q == S_ARG);
`endif

    case (state_q)
      S_CMD: begin
        if (consume) begin
          if (rx_rdata == 8'h0D) begin
`ifdef UART_CMD_ECHO_EN
            blank_d = 1'b1;
            state_d = S_LF;
`endif
          end else if (rx_rdata >= 8'h21 && rx_rdata <= 8'h7E) begin
            code_d       = rx_rdata;
            acc_d        = 32'd0;
            arg0_d       = 32'd0;
            arg1_d       = 32'd0;
            nargs_d      = 2'd0;
            digit_seen_d = 1'b0;
            err_d        = 1'b0;
            state_d      = S_ARG;
          end
        end
      end
      S_ARG: begin
        if (consume) begin
          if (hex[4]) begin
            acc_d        = {acc_q[27:0], hex[3:0]};
            digit_seen_d = 1'b1;
          end else if (rx_rdata == 8'h20 || rx_rdata == 8'h0D) begin
            // A separator closes the pending field; a third field only flags an error.
            if (digit_seen_q) begin
              case (nargs_q)
                2'd0: begin arg0_d = acc_q; nargs_d = 2'd1; end
                2'd1: begin arg1_d = acc_q; nargs_d = 2'd2; end
                default: err_d = 1'b1;
              endcase
              acc_d        = 32'd0;
              digit_seen_d = 1'b0;
            end
            if (rx_rdata == 8'h0D) begin
`ifdef UART_CMD_ECHO_EN
              blank_d = 1'b0;
              state_d = S_LF;
`else
              state_d = S_WAIT;
`endif
            end
          end else if (rx_rdata != 8'h0A) begin
            err_d = 1'b1;
          end
        end
      end
`ifdef UART_CMD_ECHO_EN
      S_LF: begin
        if (rst_n && !tx_fifo_full) begin
          lf_wr   = 1'b1;
          state_d = blank_q ? S_CMD : S_WAIT;
        end
      end
`endif
      S_WAIT: begin
        if (cmd_ack)
          state_d = S_CMD;
      end
      default: state_d = S_CMD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_CMD;
      code_q       <= 8'd0;
      arg0_q       <= 32'd0;
      arg1_q       <= 32'd0;
      acc_q        <= 32'd0;
      nargs_q      <= 2'd0;
      err_q        <= 1'b0;
      digit_seen_q <= 1'b0;
`ifdef UART_CMD_ECHO_EN
      blank_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      arg0_q       <= arg0_d;
      arg1_q       <= arg1_d;
      acc_q        <= acc_d;
      nargs_q      <= nargs_d;
      err_q        <= err_d;
      digit_seen_q <= digit_seen_d;
`ifdef UART_CMD_ECHO_EN
      blank_q      <= blank_d;
`endif
    end
  end

  assign rx_rden   = consume;
`ifdef UART_CMD_ECHO_EN
  assign tx_wten   = consume | lf_wr;
  assign tx_wdata  = lf_wr ? 8'h0A : (consume ? rx_rdata : 8'h00);
`else
  assign tx_wten   = 1'b0;
  assign tx_wdata  = 8'h00;
`endif
  assign cmd_valid = (state_q == S_WAIT);
  assign cmd_code  = code_q;
  assign cmd_arg0  = arg0_q;
  assign cmd_arg1  = arg1_q;
  assign cmd_nargs = nargs_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: byte-queue RX FIFO, line-level command model and scoreboard,
// plus literal checks; follows UART_CMD_ECHO_EN the same way the design does.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_fifo_dvalid = 1'b0;
  logic [7:0]  rx_rdata = 8'h00;
  logic        rx_rden;
  logic        tx_fifo_full = 1'b0;
  logic [7:0]  tx_wdata;
  logic        tx_wten;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [31:0] cmd_arg0;
  logic [31:0] cmd_arg1;
  logic [1:0]  cmd_nargs;
  logic        cmd_err;
  logic        cmd_ack = 1'b0;

  typedef struct {
    logic [7:0]  code;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [1:0]  n;
    logic        e;
  } rec_t;

  byte unsigned rxq[$];
  byte unsigned echoExp[$];
  byte unsigned echoGot[$];
  rec_t         expq[$];
  int           nChecks = 0;
  int           nFails = 0;
  logic         popNext = 1'b0;
  logic         prevValid = 1'b0;

  uart_cmd_parser dut (
    .clk(clk), .rst_n(rst_n),
    .rx_fifo_dvalid(rx_fifo_dvalid), .rx_rdata(rx_rdata), .rx_rden(rx_rden),
    .tx_fifo_full(tx_fifo_full), .tx_wdata(tx_wdata), .tx_wten(tx_wten),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_arg0(cmd_arg0),
    .cmd_arg1(cmd_arg1), .cmd_nargs(cmd_nargs), .cmd_err(cmd_err), .cmd_ack(cmd_ack)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit isHex(input byte unsigned c);
    return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66);
  endfunction

  function automatic int hexVal(input byte unsigned c);
    if (c <= 8'h39) return int'(c) - 48;
    if (c <= 8'h46) return int'(c) - 55;
    return int'(c) - 87;
  endfunction

  // Line-level reference: first printable byte is the command, then whitespace-separated
  // hex tokens up to CR; each token's value is its last 8 digits.
  function automatic bit modelLine(input string s, output rec_t r);
    logic [31:0]  toks[$];
    logic [31:0]  cur;
    bit           inTok;
    byte unsigned c;
    int           i;
    int           nt;
    r = '{code: 8'h00, a0: 32'h0, a1: 32'h0, n: 2'd0, e: 1'b0};
    i = 0;
    while (i < s.len()) begin
      c = s[i];
      if ((c >= 8'h21 && c <= 8'h7E) || c == 8'h0D) break;
      i++;
    end
    if (i >= s.len()) return 1'b0;
    c = s[i];
    if (c == 8'h0D) return 1'b0;
    r.code = c;
    cur = 32'h0;
    inTok = 1'b0;
    for (int j = i + 1; j < s.len(); j++) begin
      c = s[j];
      if (isHex(c)) begin
        cur = (cur << 4) + 32'(hexVal(c));
        inTok = 1'b1;
      end else if (c == 8'h20 || c == 8'h0D) begin
        if (inTok) toks.push_back(cur);
        cur = 32'h0;
        inTok = 1'b0;
        if (c == 8'h0D) break;
      end else if (c != 8'h0A) begin
        r.e = 1'b1;
      end
    end
    nt = toks.size();
    if (nt > 2) r.e = 1'b1;
    r.n  = (nt > 2) ? 2'd2 : 2'(nt);
    r.a0 = (nt > 0) ? toks[0] : 32'h0;
    r.a1 = (nt > 1) ? toks[1] : 32'h0;
    return 1'b1;
  endfunction

  // RX FIFO emulation: the pop seen before a rising edge takes effect just after it.
  always begin
    @(negedge clk);
    popNext = rx_rden;
    if (tx_wten) echoGot.push_back(tx_wdata);
    @(posedge clk);
    #1;
    if (popNext && rxq.size() > 0) void'(rxq.pop_front());
    rx_fifo_dvalid = (rxq.size() != 0);
    rx_rdata = (rxq.size() != 0) ? rxq[0] : 8'h00;
  end

  // Scoreboard: every cycle a record is presented it must match the oldest modelled line.
  always @(negedge clk) begin
    if (!rst_n) begin
      prevValid = 1'b0;
    end else begin
      if (cmd_valid && !prevValid)
        checkOutput("sb_cmd_expected", 32'(expq.size() != 0), 32'd1);
      if (cmd_valid && expq.size() != 0) begin
        checkOutput("sb_code", 32'(cmd_code), 32'(expq[0].code));
        checkOutput("sb_arg0", cmd_arg0, expq[0].a0);
        checkOutput("sb_arg1", cmd_arg1, expq[0].a1);
        checkOutput("sb_nargs", 32'(cmd_nargs), 32'(expq[0].n));
        checkOutput("sb_err", 32'(cmd_err), 32'(expq[0].e));
      end
      if (prevValid && !cmd_valid && expq.size() != 0) void'(expq.pop_front());
`ifndef UART_CMD_ECHO_EN
      checkOutput("sb_tx_idle", {23'd0, tx_wten, tx_wdata}, 32'd0);
`endif
      prevValid = cmd_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input string s, input bit modelIt);
    rec_t         r;
    byte unsigned b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      rxq.push_back(b);
      echoExp.push_back(b);
      if (b == 8'h0D) echoExp.push_back(8'h0A);
    end
    if (modelIt && modelLine(s, r)) expq.push_back(r);
  endtask

  task automatic waitValid(input string name, input int budget);
    int k;
    k = 0;
    while (!cmd_valid && k < budget) begin
      tick();
      k++;
    end
    if (!cmd_valid) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic expectCmd(input string name, input logic [7:0] code, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [1:0] n, input logic e);
    checkOutput({name, "_code"}, 32'(cmd_code), 32'(code));
    checkOutput({name, "_arg0"}, cmd_arg0, a0);
    checkOutput({name, "_arg1"}, cmd_arg1, a1);
    checkOutput({name, "_nargs"}, 32'(cmd_nargs), 32'(n));
    checkOutput({name, "_err"}, 32'(cmd_err), 32'(e));
  endtask

  task automatic ackCmd(input string name);
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    checkOutput({name, "_valid_drop"}, 32'(cmd_valid), 32'd0);
  endtask

  task automatic runLine(input string name, input string s, input logic [7:0] code,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] n,
                         input logic e);
    applyStimulus(s, 1'b1);
    waitValid(name, 200);
    expectCmd(name, code, a0, a1, n, e);
    ackCmd(name);
  endtask

  task automatic checkResetOutputs(input string name);
    checkOutput({name, "_rden"}, 32'(rx_rden), 32'd0);
    checkOutput({name, "_wten"}, 32'(tx_wten), 32'd0);
    checkOutput({name, "_wdata"}, 32'(tx_wdata), 32'd0);
    checkOutput({name, "_valid"}, 32'(cmd_valid), 32'd0);
    expectCmd(name, 8'h00, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d checks so far", nChecks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int k;
    repeat (3) tick();
    checkResetOutputs("reset");
    rst_n = 1'b1;
    tick();

    runLine("w_line", "w 1000 DEADbeef\015", 8'h77, 32'h0000_1000, 32'hDEAD_BEEF, 2'd2, 1'b0);
    runLine("r_long", "r 123456789\015", 8'h72, 32'h2345_6789, 32'h0, 2'd1, 1'b0);
    runLine("g_noarg", "g\015", 8'h67, 32'h0, 32'h0, 2'd0, 1'b0);
    runLine("x_three", "x 1 2 3\015", 8'h78, 32'h1, 32'h2, 2'd2, 1'b1);
    runLine("r_baddig", "r 1g\015", 8'h72, 32'h1, 32'h0, 2'd1, 1'b1);
    applyStimulus(" \n\015", 1'b1);
    runLine("q_lead", "  q a\n\015", 8'h71, 32'hA, 32'h0, 2'd1, 1'b0);

    // TX backpressure with a line already waiting in the RX FIFO.
    tx_fifo_full = 1'b1;
    applyStimulus("a 5\015", 1'b1);
`ifdef UART_CMD_ECHO_EN
    for (int i = 0; i < 50; i++) begin
      tick();
      checkOutput("full_hold_rden", 32'(rx_rden), 32'd0);
    end
    checkOutput("full_hold_depth", 32'(rxq.size()), 32'd4);
    tx_fifo_full = 1'b0;
    #1;
    checkOutput("full_release_rden0", 32'(rx_rden), 32'd1);
    for (int i = 1; i < 4; i++) begin
      tick();
      checkOutput("full_release_rden", 32'(rx_rden), 32'd1);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("full_ignored_rden", 32'(rx_rden), 32'd1);
    end
    tx_fifo_full = 1'b0;
`endif
    waitValid("a_bp", 200);
    expectCmd("a_bp", 8'h61, 32'h5, 32'h0, 2'd1, 1'b0);
    ackCmd("a_bp");

    // Held command blocks RX consumption until acknowledged.
    applyStimulus("z 9\015", 1'b1);
    applyStimulus("c 7\015", 1'b1);
    waitValid("z_hold", 200);
    for (int i = 0; i < 100; i++) begin
      tick();
      checkOutput("hold_rden", 32'(rx_rden), 32'd0);
    end
    checkOutput("hold_depth", 32'(rxq.size()), 32'd4);
    expectCmd("z_hold", 8'h7A, 32'h9, 32'h0, 2'd1, 1'b0);
    ackCmd("z_hold");
    checkOutput("ack_next_rden", 32'(rx_rden), 32'd1);
    waitValid("c_after", 200);
    expectCmd("c_after", 8'h63, 32'h7, 32'h0, 2'd1, 1'b0);
    ackCmd("c_after");

    // Reset in the middle of a line discards it.
    applyStimulus("w 12", 1'b0);
    k = 0;
    while ((rxq.size() != 0 || rx_fifo_dvalid) && k < 50) begin
      tick();
      k++;
    end
    tick();
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    tick();
    rst_n = 1'b1;
    tick();
    runLine("r_post", "r 5\015", 8'h72, 32'h5, 32'h0, 2'd1, 1'b0);

    repeat (5) tick();
    checkOutput("model_drained", 32'(expq.size()), 32'd0);
`ifdef UART_CMD_ECHO_EN
    checkOutput("echo_len", 32'(echoGot.size()), 32'(echoExp.size()));
    for (int i = 0; i < echoExp.size() && i < echoGot.size(); i++)
      checkOutput("echo_byte", 32'(echoGot[i]), 32'(echoExp[i]));
`else
    checkOutput("echo_none", 32'(echoGot.size()), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
